// File: rtl/snc_ram_dma_pkg.sv
// Shared definitions for the snc_ram_dma block-copy engine.
package snc_ram_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } dma_state_t;

   // Control-register bit that selects fill mode instead of copy.
   localparam int unsigned FILL_BIT = 7;

endpackage

// File: rtl/snc_ram_dma.sv
// Block-copy engine driving a single-port synchronous RAM (read data one clock after read).
// Optional fill mode (constant pattern, one word per clock) is enabled by SNC_RAM_DMA_FILL_EN.
module snc_ram_dma
   import snc_ram_dma_pkg::*;
#(
   parameter int adr_width  = 10,
   parameter int data_width = 8
)(
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [adr_width-1:0]  src_adr,
   input  logic [adr_width-1:0]  dst_adr,
   input  logic [adr_width:0]    len,
`ifdef SNC_RAM_DMA_FILL_EN
   input  logic                  fill,
   input  logic [data_width-1:0] fill_data,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [adr_width:0]    remaining,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [adr_width-1:0]  mem_adr,
   output logic [data_width-1:0] mem_din,
   input  logic [data_width-1:0] mem_dout
);

   localparam logic [adr_width:0] REM_ONE = (adr_width+1)'(1);

   dma_state_t             r_state;
   logic [adr_width-1:0]   r_src;
   logic [adr_width-1:0]   r_dst;
   logic [adr_width:0]     r_rem;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_mem_en;
   logic                   r_mem_we;
   logic [adr_width-1:0]   r_mem_adr;

   logic [adr_width-1:0]   w_src_inc;
   logic [adr_width-1:0]   w_dst_inc;
   logic                   w_last;
   logic                   w_fill_req;
   logic                   w_fill_mode;

   // Increments wrap naturally at 2**adr_width.
   assign w_src_inc = r_src + 1'b1;
   assign w_dst_inc = r_dst + 1'b1;
   assign w_last    = (r_rem == REM_ONE);

`ifdef SNC_RAM_DMA_FILL_EN
   logic                   r_fill;
   logic [data_width-1:0]  r_fill_data;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_fill      <= 1'b0;
         r_fill_data <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_fill      <= fill;
         r_fill_data <= fill_data;
      end
   end

   assign w_fill_req  = fill;
   assign w_fill_mode = r_fill;
   assign mem_din     = !r_mem_we ? '0 : (r_fill ? r_fill_data : mem_dout);
`else
   assign w_fill_req  = 1'b0;
   assign w_fill_mode = 1'b0;
   // Write data is the word the RAM returns for the preceding read cycle.
   assign mem_din     = r_mem_we ? mem_dout : '0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= ST_IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_rem     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_mem_adr <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_src <= src_adr;
                  r_dst <= dst_adr;
                  r_rem <= len;
                  if (len == '0) begin
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                  end else if (w_fill_req) begin
                     r_state   <= ST_WRITE;
                     r_busy    <= 1'b1;
                     r_mem_en  <= 1'b1;
                     r_mem_we  <= 1'b1;
                     r_mem_adr <= dst_adr;
                  end else begin
                     r_state   <= ST_READ;
                     r_busy    <= 1'b1;
                     r_mem_en  <= 1'b1;
                     r_mem_we  <= 1'b0;
                     r_mem_adr <= src_adr;
                  end
               end
            end
            ST_READ: begin
               if (abort) begin
                  r_state  <= ST_FINISH;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_mem_en <= 1'b0;
               end else begin
                  r_state   <= ST_WRITE;
                  r_mem_we  <= 1'b1;
                  r_mem_adr <= r_dst;
               end
            end
            ST_WRITE: begin
               // The write issued this cycle always lands, even when aborting.
               r_src <= w_src_inc;
               r_dst <= w_dst_inc;
               r_rem <= r_rem - 1'b1;
               if (w_last || abort) begin
                  r_state  <= ST_FINISH;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
               end else if (w_fill_mode) begin
                  r_mem_adr <= w_dst_inc;
               end else begin
                  r_state   <= ST_READ;
                  r_mem_we  <= 1'b0;
                  r_mem_adr <= w_src_inc;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign remaining = r_rem;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_adr   = r_mem_adr;

endmodule

// File: tb/tb_snc_ram_dma.sv
// Randomized scoreboard bench for snc_ram_dma with a behavioural RAM and copy model.
// Fill-mode tests run when SNC_RAM_DMA_FILL_EN is defined.
module tb_snc_ram_dma;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_adr = '0;
   logic [AW-1:0] dst_adr = '0;
   logic [AW:0]   len = '0;
`ifdef SNC_RAM_DMA_FILL_EN
   logic          fill = 1'b0;
   logic [DW-1:0] fill_data = '0;
`endif
   logic          busy, done, mem_en, mem_we;
   logic [AW:0]   remaining;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int busy_cnt = 0;

   logic [DW-1:0] ram   [DEPTH];
   logic [DW-1:0] model [DEPTH];

   typedef struct { int adr; int data; } wr_t;
   typedef struct { int rem; int cyc; int busy_cycles; } done_t;
   wr_t   wr_q[$];
   int    rd_q[$];
   done_t done_q[$];

   snc_ram_dma #(.adr_width(AW), .data_width(DW)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .abort     (abort),
      .src_adr   (src_adr),
      .dst_adr   (dst_adr),
      .len       (len),
`ifdef SNC_RAM_DMA_FILL_EN
      .fill      (fill),
      .fill_data (fill_data),
`endif
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous RAM, read data registered.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_adr] <= mem_din;
         else        mem_dout     <= ram[mem_adr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a RAM access or a done pulse.
   always @(negedge clk) begin
      if (!nrst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (mem_en) check("en_only_while_busy", busy, 1);
         if (mem_en && mem_we) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write_adr", mem_adr, 64'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               check("wr_adr", mem_adr, w.adr);
               check("wr_data", mem_din, w.data);
            end
         end
         if (mem_en && !mem_we) begin
            if (rd_q.size() == 0) begin
               check("unexpected_read_adr", mem_adr, 64'hFFFF_FFFF);
            end else begin
               int a;
               a = rd_q.pop_front();
               check("rd_adr", mem_adr, a);
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               done_t d;
               d = done_q.pop_front();
               check("done_remaining", remaining, d.rem);
               check("done_cycle", cyc, d.cyc);
               check("busy_cycles", busy_cnt, d.busy_cycles);
               check("busy_low_at_done", busy, 0);
               $display("transfer done: remaining=%0d cycle=%0d busy_cycles=%0d", remaining, cyc, busy_cnt);
            end
            busy_cnt = 0;
         end
      end
   end

   // Issue a copy; abort_k>0 raises abort in cycle abort_k after the start cycle.
   task automatic do_copy(input int s, input int d, input int n, input int abort_k, input bit busy_start);
      int words, reads, done_off, bcyc, c0;
      if (abort_k > 0 && abort_k <= 2*n) begin
         words = abort_k / 2;
         reads = (abort_k + 1) / 2;
         done_off = abort_k + 1;
         bcyc = abort_k;
      end else begin
         words = n;
         reads = n;
         done_off = 2*n + 1;
         bcyc = 2*n;
      end
      for (int i = 0; i < reads; i++) rd_q.push_back((s + i) % DEPTH);
      for (int i = 0; i < words; i++) begin
         int a;
         logic [DW-1:0] v;
         a = (d + i) % DEPTH;
         v = model[(s + i) % DEPTH];
         model[a] = v;
         wr_q.push_back('{a, int'(v)});
      end
      @(posedge clk); #1;
      c0 = cyc;
      done_q.push_back('{n - words, c0 + done_off, bcyc});
      start = 1'b1;
      src_adr = AW'(s);
      dst_adr = AW'(d);
      len = (AW+1)'(n);
`ifdef SNC_RAM_DMA_FILL_EN
      fill = 1'b0;
`endif
      @(posedge clk); #1;
      for (int t = 1; t <= done_off + 2; t++) begin
         abort = (t == abort_k);
         start = (t == 3 && busy_start && done_off > 4);
         if (start) begin
            src_adr = AW'($urandom);
            dst_adr = AW'($urandom);
            len = (AW+1)'($urandom_range(0, 20));
`ifdef SNC_RAM_DMA_FILL_EN
            fill = 1'($urandom);
`endif
         end
         @(posedge clk); #1;
      end
      abort = 1'b0;
      start = 1'b0;
      check("done_seen", done_q.size(), 0);
      check("writes_all_seen", wr_q.size(), 0);
      check("reads_all_seen", rd_q.size(), 0);
   endtask

`ifdef SNC_RAM_DMA_FILL_EN
   task automatic do_fill(input int d, input int n, input int val);
      int c0;
      for (int i = 0; i < n; i++) begin
         model[(d + i) % DEPTH] = DW'(val);
         wr_q.push_back('{(d + i) % DEPTH, val});
      end
      @(posedge clk); #1;
      c0 = cyc;
      done_q.push_back('{0, c0 + n + 1, n});
      start = 1'b1;
      src_adr = AW'($urandom);
      dst_adr = AW'(d);
      len = (AW+1)'(n);
      fill = 1'b1;
      fill_data = DW'(val);
      @(posedge clk); #1;
      start = 1'b0;
      fill = 1'b0;
      repeat (n + 3) begin @(posedge clk); #1; end
      check("fill_done_seen", done_q.size(), 0);
      check("fill_writes_seen", wr_q.size(), 0);
   endtask
`endif

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_remaining"}, remaining, 0);
      check({tag, "_mem_en"}, mem_en, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_adr"}, mem_adr, 0);
      check({tag, "_mem_din"}, mem_din, 0);
   endtask

   initial begin
      int c0, mism, orig;
      int lst[4];
      lst = '{11, 22, 33, 44};
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = DW'($urandom);
         model[i] = ram[i];
      end
      for (int i = 0; i < 4; i++) begin
         ram[16 + i] = DW'(lst[i]);
         model[16 + i] = DW'(lst[i]);
      end
      #23;
      check_outputs_zero("reset");
      @(posedge clk); #1;
      nrst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // Directed copy of four words
      do_copy(16, 256, 4, 0, 0);
      for (int i = 0; i < 4; i++) check("copy4_ram", ram[256 + i], lst[i]);

      // Zero length
      do_copy(5, 6, 0, 0, 0);

      // Address wrap with forward propagation
      orig = int'(ram[DEPTH - 2]);
      do_copy(DEPTH - 2, 0, 3, 0, 0);
      check("wrap_ram2", ram[2], orig);

      // Abort during 3rd write plus an ignored start while busy
      do_copy(32, 768, 8, 6, 1);
      // Abort during a read
      do_copy(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), 5, 3, 0);

      // Asynchronous reset mid-transfer
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b1; src_adr = AW'(64); dst_adr = AW'(128); len = (AW+1)'(4);
`ifdef SNC_RAM_DMA_FILL_EN
      fill = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
         rd_q.push_back(64 + i);
         wr_q.push_back('{128 + i, int'(model[64 + i])});
      end
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < c0 + 4) begin @(posedge clk); #1; end
      #2 nrst = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      wr_q.delete(); rd_q.delete(); done_q.delete();
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_reset_mem_en", mem_en, 0);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = ram[i];

      // Randomized transfers with occasional aborts and ignored starts
      for (int r = 0; r < 20; r++) begin
         int n, k;
         n = int'($urandom_range(0, 12));
         k = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2*n)) : 0;
         do_copy(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), n, k, 1'($urandom));
      end
      // Full-size overlapping copy
      do_copy(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), DEPTH, 0, 0);

`ifdef SNC_RAM_DMA_FILL_EN
      do_fill(512, 16, 8'hA5);
      for (int i = 0; i < 16; i++) check("fill_ram", ram[512 + i], 8'hA5);
      do_fill(int'($urandom_range(0, DEPTH-1)), 0, 8'h3C);
      do_fill(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, 9)), int'($urandom_range(0, 255)));
`endif

      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) mism++;
      check("ram_vs_model_mismatches", mism, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
